// File: rtl/exe_muldiv.sv
// Iterative RV32M multiply/divide unit for the EXE stage: one bit per cycle over magnitudes,
// with sign fix-up afterwards; stalls the front end while busy and emits a one-cycle result.
module exe_muldiv #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] operand_a_i,
  input  logic [XLEN-1:0] operand_b_i,
  input  logic [4:0]      rd_in_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      result_rd_o
);

  localparam int IDX_W = $clog2(XLEN);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   a_q, a_d, b_q, b_d, result_q, result_d;
  logic [2:0]        op_q, op_d;
  logic [4:0]        rd_q, rd_d, result_rd_q, result_rd_d;
  logic              neg_q, neg_d;

  logic aSigned, bSigned, aNeg, bNeg, divByZero, divOverflow;
  logic [IDX_W-1:0]  bitIdx;
  logic [XLEN:0]     mulSum, divShift, divDiff;
  logic [2*XLEN-1:0] prodFix;
  logic [XLEN-1:0]   quoFix, remFix;

  // MULHSU treats only rs1 as signed; unsigned ops never flag a negative operand
  assign aSigned     = op_i[2] ? ~op_i[0] : (op_i[1:0] != 2'b11);
  assign bSigned     = op_i[2] ? ~op_i[0] : ~op_i[1];
  assign aNeg        = aSigned & operand_a_i[XLEN-1];
  assign bNeg        = bSigned & operand_b_i[XLEN-1];
  assign divByZero   = op_i[2] & (operand_b_i == '0);
  assign divOverflow = op_i[2] & ~op_i[0] & (operand_a_i == MIN_INT) & (operand_b_i == '1);

  // acc holds {product} for multiply and {remainder, quotient} for divide
  assign bitIdx   = cnt_q[IDX_W-1:0];
  assign mulSum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (b_q[bitIdx] ? {1'b0, a_q} : '0);
  assign divShift = {acc_q[2*XLEN-1:XLEN], a_q[IDX_MAX - bitIdx]};
  assign divDiff  = divShift - {1'b0, b_q};

  assign prodFix = neg_q ? -acc_q : acc_q;
  assign quoFix  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
  assign remFix  = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    rd_d        = rd_q;
    neg_d       = neg_q;
    result_d    = result_q;
    result_rd_d = result_rd_q;
    case (state_q)
      IDLE: begin
        if (start_i && !flush_i) begin
          op_d  = op_i;
          rd_d  = rd_in_i;
          acc_d = '0;
          cnt_d = '0;
          a_d   = aNeg ? -operand_a_i : operand_a_i;
          b_d   = bNeg ? -operand_b_i : operand_b_i;
          neg_d = (op_i[2] & op_i[1]) ? aNeg : (aNeg ^ bNeg);
          if (divByZero) begin
            result_d    = op_i[1] ? operand_a_i : '1;
            result_rd_d = rd_in_i;
            state_d     = DONE;
          end else if (divOverflow) begin
            result_d    = op_i[1] ? '0 : MIN_INT;
            result_rd_d = rd_in_i;
            state_d     = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (op_q[2]) begin
          if (!divDiff[XLEN]) acc_d = {divDiff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
          else                acc_d = {divShift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        end else begin
          acc_d = {mulSum, acc_q[XLEN-1:1]};
        end
        if (cnt_q == CNT_W'(XLEN - 1)) begin
          cnt_d   = '0;
          state_d = SIGN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SIGN: begin
        case (op_q)
          3'b000:                 result_d = prodFix[XLEN-1:0];
          3'b001, 3'b010, 3'b011: result_d = prodFix[2*XLEN-1:XLEN];
          3'b100, 3'b101:         result_d = quoFix;
          default:                result_d = remFix;
        endcase
        result_rd_d = rd_q;
        state_d     = DONE;
      end
      DONE: state_d = IDLE;
    endcase
    // a flush abandons the op without touching the last delivered result
    if (flush_i) begin
      state_d     = IDLE;
      cnt_d       = '0;
      result_d    = result_q;
      result_rd_d = result_rd_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      rd_q        <= '0;
      neg_q       <= 1'b0;
      result_q    <= '0;
      result_rd_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      rd_q        <= rd_d;
      neg_q       <= neg_d;
      result_q    <= result_d;
      result_rd_q <= result_rd_d;
    end
  end

  assign stall_o     = ((state_q == IDLE) & start_i & ~flush_i) | (state_q == CALC) | (state_q == SIGN);
  assign done_o      = (state_q == DONE);
  assign result_o    = result_q;
  assign result_rd_o = result_rd_q;

endmodule

// File: tb/tb_exe_muldiv.sv
// Directed self-checking bench for exe_muldiv: latency, stall, results, fast paths,
// flush, held start, back-to-back issue and mid-operation reset.
module tb_exe_muldiv;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [2:0]  op;
  logic [31:0] operandA, operandB;
  logic [4:0]  rdIn;
  logic        stall, done;
  logic [31:0] result;
  logic [4:0]  resultRd;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  exe_muldiv dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start),
    .op_i        (op),
    .operand_a_i (operandA),
    .operand_b_i (operandB),
    .rd_in_i     (rdIn),
    .flush_i     (flush),
    .stall_o     (stall),
    .done_o      (done),
    .result_o    (result),
    .result_rd_o (resultRd)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Issues one op at the current falling edge; returns the cycle done was seen in (-1 on timeout)
  task automatic applyStimulus(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] rd, input bit hold, output int latency, output bit stallOk);
    start = 1'b1; op = o; operandA = a; operandB = b; rdIn = rd;
    #1;
    stallOk = (stall === 1'b1);
    latency = -1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      if (done === 1'b1) begin
        latency = cyc;
        start   = 1'b0;
        break;
      end
      if (stall !== 1'b1) stallOk = 1'b0;
    end
    start = 1'b0;
    if (stall !== 1'b0) stallOk = 1'b0;
  endtask

  task automatic runOp(input string tag, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] expRes, input int expLat, input bit hold);
    int latency;
    bit stallOk;
    applyStimulus(o, a, b, rd, hold, latency, stallOk);
    checkOutput({tag, " latency"}, 32'(latency), 32'(expLat));
    checkOutput({tag, " stall"}, {31'b0, stallOk}, 32'd1);
    checkOutput({tag, " result"}, result, expRes);
    checkOutput({tag, " rd"}, {27'b0, resultRd}, {27'b0, rd});
    @(negedge clk);
    checkOutput({tag, " done pulse"}, {31'b0, done}, 32'd0);
    checkOutput({tag, " result hold"}, result, expRes);
  endtask

  initial begin
    bit sawDone;
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; operandA = '0; operandB = '0; rdIn = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset done", {31'b0, done}, 32'd0);
    checkOutput("reset result", result, 32'd0);
    checkOutput("reset rd", {27'b0, resultRd}, 32'd0);
    checkOutput("reset stall", {31'b0, stall}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] multiply");
    runOp("MUL 7*-3",      3'b000, 32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 34, 1'b0);
    runOp("MULHU -1*-1",   3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  32'hFFFFFFFE, 34, 1'b0);
    runOp("MULH -1*-1",    3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'h00000000, 34, 1'b0);
    runOp("MULHSU -1*2",   3'b010, 32'hFFFFFFFF, 32'd2,        5'd8,  32'hFFFFFFFF, 34, 1'b0);

    $display("[TB] divide");
    runOp("DIV -7/2",      3'b100, 32'hFFFFFFF9, 32'd2,        5'd9,  32'hFFFFFFFD, 34, 1'b0);
    runOp("REM -7/2",      3'b110, 32'hFFFFFFF9, 32'd2,        5'd10, 32'hFFFFFFFF, 34, 1'b0);
    runOp("DIVU 100/7",    3'b101, 32'd100,      32'd7,        5'd11, 32'd14,       34, 1'b0);
    runOp("REMU 100/7",    3'b111, 32'd100,      32'd7,        5'd12, 32'd2,        34, 1'b0);

    $display("[TB] flush mid-operation");
    start = 1'b1; op = 3'b000; operandA = 32'd3; operandB = 32'd5; rdIn = 5'd20;
    sawDone = 1'b0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (done === 1'b1) sawDone = 1'b1;
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    if (done === 1'b1) sawDone = 1'b1;
    checkOutput("flush idle stall", {31'b0, stall}, 32'd0);
    checkOutput("flush no done", {31'b0, sawDone}, 32'd0);
    checkOutput("flush result kept", result, 32'd2);
    checkOutput("flush rd kept", {27'b0, resultRd}, 32'd12);
    @(negedge clk);
    runOp("DIVU 9/3 after flush", 3'b101, 32'd9, 32'd3, 5'd13, 32'd3, 34, 1'b0);

    start = 1'b1; flush = 1'b1; op = 3'b000; operandA = 32'd1; operandB = 32'd1; rdIn = 5'd1;
    #1;
    checkOutput("flush+start stall", {31'b0, stall}, 32'd0);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    #1;
    checkOutput("flush+start not accepted", {31'b0, stall}, 32'd0);
    @(negedge clk);

    $display("[TB] divide fast paths");
    runOp("DIVU x/0",      3'b101, 32'h00001234, 32'd0,        5'd14, 32'hFFFFFFFF, 1, 1'b0);
    runOp("REMU x/0",      3'b111, 32'h00001234, 32'd0,        5'd15, 32'h00001234, 1, 1'b0);
    runOp("REM -5/0",      3'b110, 32'hFFFFFFFB, 32'd0,        5'd16, 32'hFFFFFFFB, 1, 1'b0);
    runOp("DIV overflow",  3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd17, 32'h80000000, 1, 1'b0);
    runOp("REM overflow",  3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd18, 32'h00000000, 1, 1'b0);

    $display("[TB] protocol");
    runOp("MUL held start", 3'b000, 32'd6,       32'd7,        5'd19, 32'd42,       34, 1'b1);
    runOp("MUL b2b",       3'b000, 32'd12345,    32'd100,      5'd21, 32'h0012D644, 34, 1'b0);
    runOp("DIV b2b",       3'b100, 32'hFFFFFF9C, 32'd7,        5'd22, 32'hFFFFFFF2, 34, 1'b0);
    runOp("REM b2b",       3'b110, 32'hFFFFFF9C, 32'd7,        5'd23, 32'hFFFFFFFE, 34, 1'b0);

    $display("[TB] reset mid-operation");
    start = 1'b1; op = 3'b000; operandA = 32'd9; operandB = 32'd9; rdIn = 5'd24;
    sawDone = 1'b0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (done === 1'b1) sawDone = 1'b1;
    end
    rst = 1'b1;
    @(negedge clk);
    if (done === 1'b1) sawDone = 1'b1;
    checkOutput("rst no done", {31'b0, sawDone}, 32'd0);
    checkOutput("rst result", result, 32'd0);
    checkOutput("rst rd", {27'b0, resultRd}, 32'd0);
    checkOutput("rst idle stall", {31'b0, stall}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    runOp("MULHU after rst", 3'b011, 32'h80000000, 32'd4,      5'd25, 32'd2,        34, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
